// File: rtl/x_tgt_arb.sv
//==============================================================================
// Module      : x_tgt_arb
// Description : Target-side round-robin request arbiter with a registered
//               tpkt output. Optional macro XTARB_TGTID_CHECK_EN drops
//               packets whose TGTID does not match ID and pulses tgt_err.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module x_tgt_arb #(
   parameter int NI  = 4,
   parameter int IDW = 3,
   parameter int SAW = 32,
   parameter int SDW = 32,
   parameter int ID  = 0,
   localparam int PW = IDW*2 + SAW + 1 + SDW/8 + SDW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NI-1:0]    ipkt_vld,
   input  logic [NI*PW-1:0] ipkt_dat,
   output logic [NI-1:0]    ipkt_gnt,
   output logic             tpkt_vld,
   output logic [PW-1:0]    tpkt_dat,
`ifdef XTARB_TGTID_CHECK_EN
   output logic             tgt_err,
`endif
   input  logic             tpkt_gnt
);

   localparam int PTRW = $clog2(NI);
   localparam logic [PTRW:0]   c_ni   = (PTRW+1)'(NI);
   localparam logic [PTRW-1:0] c_last = PTRW'(NI-1);

   logic [PTRW-1:0] r_ptr;
   logic            r_vld;
   logic [PW-1:0]   r_dat;

   logic [PTRW:0]   w_idx;
   logic            w_found;
   logic [PTRW-1:0] w_win;
   logic            w_free;
   logic            w_take;
   logic            w_load;
   logic [PW-1:0]   w_win_dat;

   // Walk ptr, ptr+1, ... modulo NI; the first active request wins.
   always_comb begin
      w_idx   = '0;
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 0; i < NI; i++) begin
         w_idx = {1'b0, r_ptr} + (PTRW+1)'(i);
         if (w_idx >= c_ni) begin
            w_idx = w_idx - c_ni;
         end
         if (!w_found && ipkt_vld[w_idx[PTRW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_idx[PTRW-1:0];
         end
      end
   end

   assign w_free    = !r_vld || tpkt_gnt;
   assign w_take    = w_found && w_free && !rst;
   assign w_win_dat = ipkt_dat[w_win*PW +: PW];
   assign ipkt_gnt  = w_take ? ({{(NI-1){1'b0}}, 1'b1} << w_win) : '0;

`ifdef XTARB_TGTID_CHECK_EN
   localparam logic [IDW-1:0] c_id = IDW'(ID);
   logic w_tgt_ok;
   logic r_err;

   assign w_tgt_ok = (w_win_dat[PW-IDW-1 -: IDW] == c_id);
   assign w_load   = w_take && w_tgt_ok;

   // A mismatching packet is still consumed so its initiator never stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_take && !w_tgt_ok;
      end
   end

   assign tgt_err = r_err;
`else
   assign w_load = w_take;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
         r_vld <= 1'b0;
         r_dat <= '0;
      end else begin
         if (w_take) begin
            r_ptr <= (w_win == c_last) ? '0 : w_win + 1'b1;
         end
         if (w_load) begin
            r_dat <= w_win_dat;
            r_vld <= 1'b1;
         end else if (tpkt_gnt) begin
            r_vld <= 1'b0;
         end
      end
   end

   assign tpkt_vld = r_vld;
   assign tpkt_dat = r_dat;

endmodule

`default_nettype wire

// File: tb/tb_x_tgt_arb.sv
//==============================================================================
// Module      : tb_x_tgt_arb
// Description : Directed scoreboard bench for x_tgt_arb.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_x_tgt_arb;

   localparam int NI  = 4;
   localparam int IDW = 3;
   localparam int SAW = 32;
   localparam int SDW = 32;
   localparam int ID  = 2;
   localparam int PW  = IDW*2 + SAW + 1 + SDW/8 + SDW;

   logic             clk = 1'b0;
   logic             rst;
   logic [NI-1:0]    ipkt_vld;
   logic [NI*PW-1:0] ipkt_dat;
   logic [NI-1:0]    ipkt_gnt;
   logic             tpkt_vld;
   logic [PW-1:0]    tpkt_dat;
   logic             tpkt_gnt;
`ifdef XTARB_TGTID_CHECK_EN
   logic             tgt_err;
`endif

   x_tgt_arb #(.NI(NI), .IDW(IDW), .SAW(SAW), .SDW(SDW), .ID(ID)) dut (
      .clk      (clk),
      .rst      (rst),
      .ipkt_vld (ipkt_vld),
      .ipkt_dat (ipkt_dat),
      .ipkt_gnt (ipkt_gnt),
      .tpkt_vld (tpkt_vld),
      .tpkt_dat (tpkt_dat),
`ifdef XTARB_TGTID_CHECK_EN
      .tgt_err  (tgt_err),
`endif
      .tpkt_gnt (tpkt_gnt)
   );

   always #5 clk = ~clk;

   int            n_vec = 0;
   int            n_err = 0;
   int            seq   = 0;
   int            m_ptr = 0;
   bit            m_vld = 1'b0;
   bit            m_err = 1'b0;
   logic [PW-1:0] q[$];
   logic [IDW-1:0] tgt_sel [NI];
   logic [PW-1:0] pkt_a5;

   task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] mk(input int port, input int s, input logic [IDW-1:0] t);
      logic [IDW-1:0] pid;
      logic [31:0]    sv;
      pid = IDW'(port);
      sv  = 32'(s);
      return {pid, t, SAW'(32'h4000_0000 + sv*4), sv[0], (SDW/8)'(sv), SDW'(32'hC0DE_0000 + sv)};
   endfunction

   task automatic refresh();
      for (int p = 0; p < NI; p++) begin
         ipkt_dat[p*PW +: PW] = mk(p, seq, tgt_sel[p]);
         seq++;
      end
   endtask

   // Checks the cycle before the edge, then advances the reference model.
   task automatic cycle(input string tag);
      bit            found;
      bit            take;
      bit            ok;
      int            win;
      int            idx;
      logic [PW-1:0] win_pkt;
      logic [NI-1:0] exp_gnt;
      #1;
      found = 1'b0;
      win   = 0;
      for (int i = 0; i < NI; i++) begin
         idx = (m_ptr + i) % NI;
         if (!found && ipkt_vld[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      take    = found && (!m_vld || tpkt_gnt) && !rst;
      exp_gnt = take ? NI'(1 << win) : '0;
      win_pkt = ipkt_dat[win*PW +: PW];
      chk({tag, ".gnt"}, PW'(ipkt_gnt), PW'(exp_gnt));
      chk({tag, ".vld"}, PW'(tpkt_vld), PW'(m_vld));
      if (m_vld && q.size() > 0) chk({tag, ".dat"}, tpkt_dat, q[0]);
`ifdef XTARB_TGTID_CHECK_EN
      chk({tag, ".err"}, PW'(tgt_err), PW'(m_err));
`endif
      @(posedge clk);
      if (rst) begin
         m_vld = 1'b0;
         m_ptr = 0;
         m_err = 1'b0;
         q.delete();
      end else begin
         if (m_vld && tpkt_gnt && q.size() > 0) void'(q.pop_front());
         ok = 1'b1;
`ifdef XTARB_TGTID_CHECK_EN
         ok = (win_pkt[PW-IDW-1 -: IDW] == IDW'(ID));
`endif
         m_err = take && !ok;
         if (take) m_ptr = (win + 1) % NI;
         if (take && ok) begin
            q.push_back(win_pkt);
            m_vld = 1'b1;
         end else if (tpkt_gnt) begin
            m_vld = 1'b0;
         end
      end
      @(negedge clk);
      refresh();
   endtask

   initial begin
      for (int p = 0; p < NI; p++) tgt_sel[p] = IDW'(ID);
      rst      = 1'b1;
      ipkt_vld = '1;
      tpkt_gnt = 1'b1;
      ipkt_dat = '0;
      refresh();
      @(negedge clk);

      // reset with every initiator requesting
      cycle("rst0");
      cycle("rst1");
      chk("rst.dat", tpkt_dat, '0);
      rst = 1'b0;
      #1 chk("rel.port0", PW'(ipkt_gnt), PW'(4'b0001));
      cycle("rel");

      // single initiator on port 2
      ipkt_vld = 4'b0100;
      pkt_a5   = {3'd2, 3'd2, 32'h0000_1234, 1'b1, 4'hF, 32'hA5A5_0001};
      ipkt_dat[2*PW +: PW] = pkt_a5;
      #1 chk("single.gnt", PW'(ipkt_gnt), PW'(4'b0100));
      cycle("single");
      ipkt_vld = '0;
      #1 chk("single.out", tpkt_dat, pkt_a5);
      cycle("single_out");

      // round robin from a fresh pointer
      rst = 1'b1;
      cycle("rst2");
      rst      = 1'b0;
      ipkt_vld = '1;
      for (int k = 0; k < 16; k++) begin
         #1 chk("rr.order", PW'(ipkt_gnt), PW'(4'b0001 << (k % 4)));
         cycle("rr");
      end

      // backpressure with ports 1 and 3
      ipkt_vld = 4'b1010;
      cycle("bp.load");
      tpkt_gnt = 1'b0;
      for (int k = 0; k < 5; k++) cycle("bp.hold");
      tpkt_gnt = 1'b1;
      #1 chk("bp.release", PW'(ipkt_gnt), PW'(4'b1000));
      cycle("bp.rel");
      ipkt_vld = '0;
      cycle("bp.drain");

      // wrap-around with sparse requests
      ipkt_vld = 4'b0100;
      cycle("wrap.p2");
      ipkt_vld = 4'b1001;
      #1 chk("wrap.p3", PW'(ipkt_gnt), PW'(4'b1000));
      cycle("wrap.a");
      #1 chk("wrap.p0", PW'(ipkt_gnt), PW'(4'b0001));
      cycle("wrap.b");
      ipkt_vld = '0;
      cycle("wrap.drain");

      // reset while a packet is held
      ipkt_vld = 4'b0001;
      cycle("mid.load");
      tpkt_gnt = 1'b0;
      cycle("mid.hold");
      rst = 1'b1;
      cycle("mid.rst");
      rst      = 1'b0;
      ipkt_vld = '0;
      tpkt_gnt = 1'b1;
      cycle("mid.after");

`ifdef XTARB_TGTID_CHECK_EN
      // misrouted packet is consumed, then a matching one is forwarded
      tgt_sel[1] = 3'd5;
      refresh();
      ipkt_vld = 4'b0010;
      cycle("tid.bad");
      ipkt_vld = '0;
      cycle("tid.pulse");
      cycle("tid.quiet");
      tgt_sel[1] = IDW'(ID);
      refresh();
      ipkt_vld = 4'b0010;
      cycle("tid.good");
      ipkt_vld = '0;
      cycle("tid.out");
      cycle("tid.idle");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/x_tgt_arb.md
Name: x_tgt_arb

Overview:
- Target-side request arbiter; sits directly upstream of the target unit's tpkt input.
- Accepts request packets from NI initiator ports, selects one per cycle by round-robin, and presents it on a registered tpkt output.
- Uses the same tpkt_vld/tpkt_dat/tpkt_gnt handshake as the target unit.
- Packet format: {INITID, TGTID, S_ADR, WE, S_STRB, S_DATA}.

Parameters:
- NI, 4, number of initiator ports (>=2).
- IDW, 3, width of INITID and TGTID fields.
- SAW, 32, address field width.
- SDW, 32, data field width; strobe width is SDW/8.
- ID, 0, this target's ID; used only under the optional feature.
- PW (localparam), IDW*2+SAW+1+SDW/8+SDW, packet width (75 at defaults).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ipkt_vld  in  NI  per-initiator packet valid.
- ipkt_dat  in  NI*PW  packets; port i occupies bits [i*PW +: PW].
- ipkt_gnt  out  NI  per-initiator accept, one-hot or zero.
- tpkt_vld  out  1  output packet valid.
- tpkt_dat  out  PW  output packet.
- tpkt_gnt  in  1  downstream accept.
- tgt_err  out  1  misrouted-packet pulse; exists only with XTARB_TGTID_CHECK_EN.

Behaviour:
- Reset (rst=1 at a clk edge): tpkt_vld=0, tpkt_dat=0, ptr=0, tgt_err=0. ipkt_gnt is 0 while rst=1. Reset mid-transfer discards the held packet.
- Handshake:
  - A transfer occurs on any edge where vld and gnt are both high.
  - Once tpkt_vld is high, tpkt_vld and tpkt_dat hold stable until tpkt_gnt.
  - Initiators may present vld without waiting for gnt.
- Slot free: free = !tpkt_vld | tpkt_gnt. This gives full throughput: one packet per cycle under continuous tpkt_gnt.
- Arbitration (combinational):
  - Search indices ptr, ptr+1, ..., ptr+NI-1, modulo NI.
  - The first index with ipkt_vld high is the winner w.
  - ipkt_gnt[w] = free. All other grants are 0.
  - No winner, or free=0: ipkt_gnt = 0.
- Output register:
  - If ipkt_gnt[w] fires: tpkt_dat <= ipkt_dat[w], tpkt_vld <= 1.
  - Else if tpkt_gnt: tpkt_vld <= 0, tpkt_dat holds.
- Latency: one cycle from the initiator's accepted edge to tpkt_vld.
- Pointer: on a grant to w, ptr <= (w+1) mod NI. Otherwise ptr holds.
  - Wrap-around: a grant to NI-1 sets ptr=0.
  - NI not a power of two must wrap correctly.
- Fairness: with all NI requesting continuously and tpkt_gnt=1, each port is granted exactly once every NI cycles.
- Backpressure: tpkt_vld=1 and tpkt_gnt=0 means free=0, so no grants and ptr frozen.
- Simultaneous pop and push (tpkt_gnt=1 and a winner in the same cycle): new packet loaded, tpkt_vld stays 1, no bubble.
- Packet contents pass through unmodified; no field is inspected except under the optional feature.

Optional Feature:
- Macro: XTARB_TGTID_CHECK_EN.
- Enabled:
  - If the winner's TGTID field (bits [PW-IDW-1 -: IDW]) != ID[IDW-1:0], the packet is still granted and consumed (ipkt_gnt[w]=1, subject to free) but not loaded into the output register.
  - tpkt_vld follows the no-load rule. tgt_err is a registered one-cycle pulse the cycle after.
  - ptr advances normally.
  - Requests to a dropped target therefore never deadlock an initiator.
- Disabled: no tgt_err port, no TGTID comparison, every granted packet is forwarded.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all ipkt_vld=1 -> ipkt_gnt=0, tpkt_vld=0, tpkt_dat=0; first cycle after release grants port 0.
- Single initiator: port 2 sends data 0xA5A5_0001 with tpkt_gnt=1 -> ipkt_gnt=4'b0100 for one cycle; next cycle tpkt_vld=1 with the identical 75-bit packet.
- Round-robin: all 4 ports request continuously, tpkt_gnt=1 -> grant order 0,1,2,3,0,1..., one packet per cycle, no bubbles over 16 cycles.
- Backpressure: tpkt_gnt=0 for 5 cycles with ports 1 and 3 valid -> tpkt_vld/tpkt_dat stable, ipkt_gnt=0, ptr frozen; on release, port 3 (ptr=2 after the prior grant to 1) is granted the same cycle tpkt_gnt=1.
- Wrap-around and sparse requests: ptr=3, only port 0 and port 3 valid -> port 3 granted, ptr=0; next cycle port 0 granted, ptr=1.
- XTARB_TGTID_CHECK_EN with ID=2: port 1 sends TGTID=5 -> ipkt_gnt[1]=1, tpkt_vld stays 0, tgt_err=1 for exactly one cycle; a following packet with TGTID=2 is forwarded normally.
